// File: rtl/regfile_scb.sv
// regfile_scb: NRD-read / 1-write integer register file with a per-register busy scoreboard
// and a self-clearing start-up sequence. Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module regfile_scb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 3,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_we,
  input  logic [AW-1:0]       iss_a,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_ptr;
  logic              r_ready;
  logic [NREGS-1:0]  r_busy;
  logic [XLEN-1:0]   r_rf [NREGS];

  logic              w_run;
  logic              w_wr_en;
  logic              w_iss_en;
  logic              w_clr_last;

  assign w_run      = (r_state == ST_RUN);
  assign w_wr_en    = w_run && we && (wa != {AW{1'b0}});
  assign w_iss_en   = w_run && iss_we && (iss_a != {AW{1'b0}});
  assign w_clr_last = (r_ptr == AW'(NREGS - 1));
  assign ready      = r_ready;

  // Start-up sequencer: walk the clear pointer over registers 1..NREGS-1, then run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_ptr   <= AW'(1);
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_ptr <= r_ptr + AW'(1);
          if (w_clr_last) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_state <= ST_CLEAR;
            r_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= AW'(1);
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Data array has no reset; the clear sequence is what zeroes it.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_rf[r_ptr] <= {XLEN{1'b0}};
    end else if (w_wr_en) begin
      r_rf[wa] <= wd;
    end
  end

  // Scoreboard: issue is applied after writeback so a same-cycle new producer wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= {NREGS{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_busy[wa] <= 1'b0;
      end
      if (w_iss_en) begin
        r_busy[iss_a] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;
    logic            w_bsy;

    assign w_ra = ra[k*AW +: AW];

    // Read port k: zero while clearing or for register 0, otherwise array/scoreboard lookup.
    always_comb begin
      w_rd  = {XLEN{1'b0}};
      w_bsy = 1'b0;
      if (w_run && (w_ra != {AW{1'b0}})) begin
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (wa == w_ra)) begin
          w_rd  = wd;
          w_bsy = w_iss_en && (iss_a == w_ra);
        end else begin
          w_rd  = r_rf[w_ra];
          w_bsy = r_busy[w_ra];
        end
`else
        w_rd  = r_rf[w_ra];
        w_bsy = r_busy[w_ra];
`endif
      end else begin
        w_rd  = {XLEN{1'b0}};
        w_bsy = 1'b0;
      end
    end

    assign rd[k*XLEN +: XLEN] = w_rd;
    assign busy[k]            = w_bsy;
  end

endmodule

// File: doc/regfile_scb.md
# regfile_scb

Parametrised integer register file with a configurable number of read ports, a per-register scoreboard and a self-clearing start-up sequence. It is the next-generation replacement for the pipeline's three-read/one-write register file. Decode reads operands and marks destination registers busy at issue; writeback writes the result and releases the busy bit. Hazard logic uses the busy flags to stall.

## Interface
Parameters:
- XLEN, 32, data width in bits (≥8).
- NREGS, 32, number of architectural registers; power of two, ≥4. AW = $clog2(NREGS) is derived, not overridable.
- NRD, 3, number of read ports (1..4).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready  out  1  high when the clear sequence is done and the file accepts writes and issues.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wd  in  XLEN  writeback data.
- iss_we  in  1  issue strobe; marks register iss_a busy.
- iss_a  in  AW  issue destination address.
- ra  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd  out  NRD*XLEN  packed read data, combinational.
- busy  out  NRD  per-port busy flag for ra[k], combinational.

## Operation
- Register 0 is hardwired to zero.
  - Reads of address 0 return 0 and busy 0.
  - Writes and issues to address 0 are ignored.
- The FSM has two states, CLEAR and RUN.
  - Reset, asserted at any time, forces CLEAR, clear pointer = 1, ready = 0 and all busy bits = 0.
  - Reset does not clear the data array; CLEAR does.
- CLEAR:
  - Each cycle, write 0 to rf[ptr] and increment ptr.
  - When ptr = NREGS-1 is written, go to RUN next cycle.
  - In CLEAR, we and iss_we are ignored, every rd is 0 and every busy is 0.
- RUN:
  - ready = 1.
  - When we = 1, rf[wa] <= wd and busy[wa] <= 0.
  - When iss_we = 1, busy[iss_a] <= 1.
- Simultaneous writeback and issue to the same nonzero address:
  - Data is written.
  - The busy bit ends at 1, because the new producer wins.
- Writeback to a register that is not busy is legal: data is written and the busy bit stays 0.
- Read ports are independent. Any number of ports may read the same address.
- No arithmetic is performed. Addresses are used unsigned, and full AW range is valid.

## Timing
- Reset values:
  - ready = 0, state = CLEAR, ptr = 1, busy[*] = 0.
  - rd = 0 and busy outputs = 0 until RUN.
- Clear latency: ready rises exactly NREGS-1 rising edges after reset deasserts (31 for the default).
- Reset asserted mid-clear restarts the pointer at 1, so the full NREGS-1 cycles repeat.
- Write and issue take effect on the rising edge. Reads are combinational from the current array and busy state.
- Read-during-write behaviour at the same address depends on REGFILE_BYPASS_EN (see Configuration).

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, if we = 1 and wa = ra[k] ≠ 0, rd[k] = wd in the same cycle.
  - busy[k] = 0 in that cycle unless iss_we = 1 with iss_a = ra[k].
  - The path is purely combinational, so write-then-read has 0-cycle latency.
- REGFILE_BYPASS_EN undefined:
  - rd[k] returns the pre-write array value and busy[k] the pre-edge busy bit.
  - The new value is visible one cycle after the write edge.
  - The pipeline must handle the hazard, for example with a one-cycle stall.

## Test plan
- Clear sequence: hold reset 3 cycles, release, drive we = 1, wa = 5, wd = 0xFFFF_FFFF every cycle.
  - ready must rise on cycle 31 after release.
  - rd for ra = 5 must read 0 until the first RUN write, then 0xFFFF_FFFF.
- Reset mid-clear: assert reset at clear cycle 10 for 1 cycle.
  - ready must still take 31 cycles from the second release.
  - All 31 registers must read 0.
- Scoreboard:
  - Issue to 7: busy for ra = 7 is 1 on the next cycle.
  - Writeback wa = 7, wd = 0x1234: busy is 0 the next cycle and rd = 0x0000_1234.
  - Writeback and issue to 7 in the same cycle: busy stays 1 and data = new wd.
- Register 0: we = 1, wa = 0, wd = 0xDEAD_BEEF plus iss_we with iss_a = 0.
  - All ports reading 0 return 0 with busy 0.
- Bypass with the macro defined: we = 1, wa = 3, wd = 0xA5A5_A5A5 while ra port 0 = 3.
  - rd port 0 = 0xA5A5_A5A5 in the same cycle.
  - Without the macro, that cycle returns the old value and the next cycle returns 0xA5A5_A5A5.
- Parametrisation: XLEN = 16, NREGS = 8, NRD = 4.
  - Ready after 7 cycles.
  - Four ports read distinct written values 0x0011, 0x0022, 0x0033, 0x0044 simultaneously.
